// File: rtl/jvm_useq_pkg.sv
// jvm_useq_pkg: shared types and constants for the JVM micro-sequencer.
//   state_t       - sequencer FSM states
//   trap_cause_t  - encoding of the trap_cause output
//   END_ADR       - next-address value that terminates a bytecode chain
//   ILLEGAL_ADR   - next-address value that marks an illegal chain (all ones)
//   UCODE_BASE    - first address of the shared microcode area
package jvm_useq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TC_NONE     = 2'd0,
        TC_ILLEGAL  = 2'd1,
        TC_BACKWARD = 2'd2,
        TC_WDOG     = 2'd3
    } trap_cause_t;

    localparam int unsigned END_ADR     = 0;
    localparam int unsigned ILLEGAL_ADR = '1;
    localparam int unsigned UCODE_BASE  = 256;

endpackage

// File: rtl/jvm_useq_wdog.sv
// jvm_useq_wdog: per-bytecode micro-op step counter with limit compare.
//   clk, rst  - clock, async active-high reset
//   clr       - restart count (opcode accepted)
//   inc       - one more micro-op accepted and the chain continues
//   trip_c    - combinational: current step is the last one allowed
module jvm_useq_wdog #(
    parameter int unsigned MAX_STEPS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic trip_c
);

    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

    logic [STEP_W-1:0] step;

    // step counter, restarted for every opcode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
        end else if (clr) begin
            step <= '0;
        end else if (inc) begin
            step <= step + STEP_W'(1);
        end
    end

    assign trip_c = (step == STEP_W'(MAX_STEPS - 1));

endmodule

// File: rtl/jvm_useq_sequencer.sv
// jvm_useq_sequencer: walks the next-address ROM chain for one bytecode at a
// time and issues one micro-op address per step; illegal chains trap.
//   bc_valid/bc_ready/bc_opcode  - opcode handshake from fetch
//   rom_adr/rom_next             - combinational next-address ROM port
//   uop_valid/uop_ready/uop_adr  - micro-op handshake to decode
//   uop_first/uop_last           - entry step / chain-ending step markers
//   trap/trap_cause/trap_clr     - sticky error flag, cause, clear
//   bc_retired                   - wrapping count of completed bytecodes
// Build option: USEQ_WATCHDOG_EN adds the MAX_STEPS micro-op watchdog.
module jvm_useq_sequencer
    import jvm_useq_pkg::*;
#(
    parameter int unsigned ADR_W     = 9,
    parameter int unsigned MAX_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bc_valid,
    output logic             bc_ready,
    input  logic [7:0]       bc_opcode,
    output logic [ADR_W-1:0] rom_adr,
    input  logic [ADR_W-1:0] rom_next,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [ADR_W-1:0] uop_adr,
    output logic             uop_first,
    output logic             uop_last,
    output logic             trap,
    output logic [1:0]       trap_cause,
    input  logic             trap_clr,
    output logic [15:0]      bc_retired
);

    state_t            state, state_nxt;
    trap_cause_t       cause, cause_nxt;
    logic [ADR_W-1:0]  upc, upc_nxt;
    logic [15:0]       retired, retired_nxt;
    logic              wdog_trip_c;

`ifdef USEQ_WATCHDOG_EN
    logic step_clr, step_inc;

    jvm_useq_wdog #(
        .MAX_STEPS (MAX_STEPS)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (step_clr),
        .inc    (step_inc),
        .trip_c (wdog_trip_c)
    );
`else
    // no watchdog: chains are unbounded; MAX_STEPS has no effect here
    assign wdog_trip_c = 1'b0 & (MAX_STEPS != 0);
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cause   <= TC_NONE;
            upc     <= '0;
            retired <= '0;
        end else begin
            state   <= state_nxt;
            cause   <= cause_nxt;
            upc     <= upc_nxt;
            retired <= retired_nxt;
        end
    end

    // next state; the handshake checks are in priority order
    always_comb begin
        state_nxt   = state;
        cause_nxt   = cause;
        upc_nxt     = upc;
        retired_nxt = retired;
`ifdef USEQ_WATCHDOG_EN
        step_clr    = 1'b0;
        step_inc    = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (bc_valid) begin
                    upc_nxt   = ADR_W'(bc_opcode);
                    state_nxt = S_ISSUE;
`ifdef USEQ_WATCHDOG_EN
                    step_clr  = 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                if (uop_ready) begin
                    if (rom_next == ADR_W'(END_ADR)) begin
                        retired_nxt = retired + 16'd1;
                        state_nxt   = S_IDLE;
                    end else if (rom_next == ADR_W'(ILLEGAL_ADR)) begin
                        cause_nxt = TC_ILLEGAL;
                        state_nxt = S_TRAP;
                    end else if (rom_next < ADR_W'(UCODE_BASE)) begin
                        cause_nxt = TC_BACKWARD;
                        state_nxt = S_TRAP;
                    end else if (wdog_trip_c) begin
                        cause_nxt = TC_WDOG;
                        state_nxt = S_TRAP;
                    end else begin
                        upc_nxt  = rom_next;
`ifdef USEQ_WATCHDOG_EN
                        step_inc = 1'b1;
`endif
                    end
                end
            end
            S_TRAP: begin
                if (trap_clr) begin
                    state_nxt = S_IDLE;
                    cause_nxt = TC_NONE;
                    upc_nxt   = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs decode directly from state/uPC flops; uop_last follows the ROM
    assign bc_ready   = (state == S_IDLE);
    assign uop_valid  = (state == S_ISSUE);
    assign trap       = (state == S_TRAP);
    assign trap_cause = cause;
    assign rom_adr    = upc;
    assign uop_adr    = upc;
    assign uop_first  = uop_valid && (upc < ADR_W'(UCODE_BASE));
    assign uop_last   = uop_valid && (rom_next == ADR_W'(END_ADR));
    assign bc_retired = retired;

endmodule

// File: tb/tb_jvm_useq_sequencer.sv
module tb_jvm_useq_sequencer;

`ifdef USEQ_WATCHDOG_EN
    localparam int unsigned MS = 2;
`else
    localparam int unsigned MS = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bc_valid;
    logic        bc_ready;
    logic [7:0]  bc_opcode;
    logic [8:0]  rom_adr;
    logic [8:0]  rom_next;
    logic        uop_valid;
    logic        uop_ready;
    logic [8:0]  uop_adr;
    logic        uop_first;
    logic        uop_last;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        trap_clr;
    logic [15:0] bc_retired;

    int passes = 0;
    int total  = 0;
    int fails  = 0;
    logic [15:0] exp_ret;

    always #5 clk = ~clk;

    jvm_useq_sequencer #(.ADR_W(9), .MAX_STEPS(MS)) dut (
        .clk        (clk),
        .rst        (rst),
        .bc_valid   (bc_valid),
        .bc_ready   (bc_ready),
        .bc_opcode  (bc_opcode),
        .rom_adr    (rom_adr),
        .rom_next   (rom_next),
        .uop_valid  (uop_valid),
        .uop_ready  (uop_ready),
        .uop_adr    (uop_adr),
        .uop_first  (uop_first),
        .uop_last   (uop_last),
        .trap       (trap),
        .trap_cause (trap_cause),
        .trap_clr   (trap_clr),
        .bc_retired (bc_retired)
    );

    // combinational next-address ROM model
    always_comb begin
        case (rom_adr)
            9'h059: rom_next = 9'h100;
            9'h100: rom_next = 9'h101;
            9'h05A: rom_next = 9'h104;
            9'h104: rom_next = 9'h103;
            9'h05B: rom_next = 9'h10C;
            9'h10C: rom_next = 9'h1FF;
            9'h05C: rom_next = 9'h108;
            9'h108: rom_next = 9'h020;
            default: rom_next = 9'h000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] op);
        bc_valid  = 1'b1;
        bc_opcode = op;
        tick();
        bc_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bc_valid = 1'b0; bc_opcode = 8'h00;
        uop_ready = 1'b1; trap_clr = 1'b0;
        exp_ret = 16'd0;
        #23;
        rst = 1'b0;
        tick();

        chk("rst_bc_ready", 32'(bc_ready), 32'd1);
        chk("rst_uop_valid", 32'(uop_valid), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        chk("rst_retired", 32'(bc_retired), 32'd0);
        chk("rst_rom_adr", 32'(rom_adr), 32'h000);

`ifndef USEQ_WATCHDOG_EN
        // 0x59: three-step chain
        accept(8'h59);
        chk("dup_s0_adr", 32'(uop_adr), 32'h059);
        chk("dup_s0_valid", 32'(uop_valid), 32'd1);
        chk("dup_s0_first", 32'(uop_first), 32'd1);
        chk("dup_s0_last", 32'(uop_last), 32'd0);
        chk("dup_s0_bc_ready", 32'(bc_ready), 32'd0);
        tick();
        chk("dup_s1_adr", 32'(uop_adr), 32'h100);
        chk("dup_s1_first", 32'(uop_first), 32'd0);
        chk("dup_s1_last", 32'(uop_last), 32'd0);
        tick();
        chk("dup_s2_adr", 32'(uop_adr), 32'h101);
        chk("dup_s2_last", 32'(uop_last), 32'd1);
        tick();
        exp_ret = exp_ret + 16'd1;
        chk("dup_idle", 32'(bc_ready), 32'd1);
        chk("dup_valid_low", 32'(uop_valid), 32'd0);
        chk("dup_retired", 32'(bc_retired), 32'(exp_ret));
`endif

        // 0x00: single micro-op
        accept(8'h00);
        chk("nop_adr", 32'(uop_adr), 32'h000);
        chk("nop_first", 32'(uop_first), 32'd1);
        chk("nop_last", 32'(uop_last), 32'd1);
        chk("nop_bc_ready_busy", 32'(bc_ready), 32'd0);
        tick();
        exp_ret = exp_ret + 16'd1;
        chk("nop_bc_ready_again", 32'(bc_ready), 32'd1);
        chk("nop_retired", 32'(bc_retired), 32'(exp_ret));

`ifndef USEQ_WATCHDOG_EN
        // 0x5A with downstream stall on 0x104
        accept(8'h5A);
        chk("stall_s0", 32'(uop_adr), 32'h05A);
        tick();
        chk("stall_s1", 32'(uop_adr), 32'h104);
        uop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_adr", 32'(uop_adr), 32'h104);
            chk("stall_hold_valid", 32'(uop_valid), 32'd1);
        end
        uop_ready = 1'b1;
        tick();
        chk("stall_s2", 32'(uop_adr), 32'h103);
        chk("stall_s2_last", 32'(uop_last), 32'd1);
        tick();
        exp_ret = exp_ret + 16'd1;
        chk("stall_retired", 32'(bc_retired), 32'(exp_ret));
`else
        // 0x5A with MAX_STEPS=2: watchdog trips on the handshake at 0x104
        accept(8'h5A);
        chk("wd_s0", 32'(uop_adr), 32'h05A);
        tick();
        chk("wd_s1", 32'(uop_adr), 32'h104);
        tick();
        chk("wd_trap", 32'(trap), 32'd1);
        chk("wd_cause", 32'(trap_cause), 32'd3);
        chk("wd_retired", 32'(bc_retired), 32'(exp_ret));
        trap_clr = 1'b1;
        tick();
        trap_clr = 1'b0;
        chk("wd_clr_cause", 32'(trap_cause), 32'd0);
`endif

        // illegal next address at 0x10C
        accept(8'h5B);
        chk("ill_s0", 32'(uop_adr), 32'h05B);
        tick();
        chk("ill_s1", 32'(uop_adr), 32'h10C);
        tick();
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        chk("ill_bc_ready", 32'(bc_ready), 32'd0);
        chk("ill_valid", 32'(uop_valid), 32'd0);
        bc_valid = 1'b1;
        tick();
        bc_valid = 1'b0;
        chk("ill_sticky", 32'(trap), 32'd1);
        chk("ill_sticky_cause", 32'(trap_cause), 32'd1);
        trap_clr = 1'b1;
        tick();
        trap_clr = 1'b0;
        chk("ill_clr_trap", 32'(trap), 32'd0);
        chk("ill_clr_cause", 32'(trap_cause), 32'd0);
        chk("ill_clr_ready", 32'(bc_ready), 32'd1);
        chk("ill_clr_upc", 32'(rom_adr), 32'h000);
        chk("ill_retired", 32'(bc_retired), 32'(exp_ret));

        // backward next address mid-chain; trap_clr during ISSUE is ignored
        accept(8'h5C);
        chk("bwd_s0", 32'(uop_adr), 32'h05C);
        trap_clr = 1'b1;
        tick();
        chk("bwd_s1", 32'(uop_adr), 32'h108);
        chk("bwd_s1_valid", 32'(uop_valid), 32'd1);
        trap_clr = 1'b0;
        tick();
        chk("bwd_trap", 32'(trap), 32'd1);
        chk("bwd_cause", 32'(trap_cause), 32'd2);
        trap_clr = 1'b1;
        tick();
        trap_clr = 1'b0;
        chk("bwd_clr", 32'(trap_cause), 32'd0);

        // reset during the 0x100 step aborts without retiring
        accept(8'h59);
        tick();
        chk("rmid_adr", 32'(uop_adr), 32'h100);
        uop_ready = 1'b0;
        rst = 1'b1;
        #2;
        exp_ret = 16'd0;
        chk("rmid_bc_ready", 32'(bc_ready), 32'd1);
        chk("rmid_valid", 32'(uop_valid), 32'd0);
        chk("rmid_trap", 32'(trap), 32'd0);
        chk("rmid_cause", 32'(trap_cause), 32'd0);
        chk("rmid_retired", 32'(bc_retired), 32'(exp_ret));
        chk("rmid_upc", 32'(rom_adr), 32'h000);
        rst = 1'b0;
        uop_ready = 1'b1;
        tick();
        accept(8'h00);
        chk("post_adr", 32'(uop_adr), 32'h000);
        chk("post_last", 32'(uop_last), 32'd1);
        tick();
        exp_ret = exp_ret + 16'd1;
        chk("post_retired", 32'(bc_retired), 32'(exp_ret));
        chk("post_ready", 32'(bc_ready), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
